// File: rtl/seq_alu_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu_if
//  Description : Request/response bundle between the EX-stage control FSM
//                and the sequential ALU (start/busy/done handshake).
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_alu_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
);
    logic             start;
    logic [5:0]       Funct;
    logic [WIDTH-1:0] Src1;
    logic [WIDTH-1:0] Src2;
    logic [SHW-1:0]   Shamt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             err;

    // Requester side (control FSM / testbench)
    modport master (
        output start, Funct, Src1, Src2, Shamt,
        input  busy, done, result, result_hi, err
    );

    // ALU side
    modport slave (
        input  start, Funct, Src1, Src2, Shamt,
        output busy, done, result, result_hi, err
    );
endinterface
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu
//  Description : Sequential MIPS-style ALU. Single-cycle addu/subu/and/or/
//                sll/srl, iterative shift-add multu and restoring divu that
//                return a HI/LO pair after WIDTH cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    seq_alu_if.slave    bus
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [5:0] c_ADDU  = 6'b001011;
    localparam logic [5:0] c_SUBU  = 6'b001101;
    localparam logic [5:0] c_AND   = 6'b010010;
    localparam logic [5:0] c_OR    = 6'b010011;
    localparam logic [5:0] c_SLL   = 6'b100110;
    localparam logic [5:0] c_SRL   = 6'b100100;
    localparam logic [5:0] c_MULTU = 6'b011001;
    localparam logic [5:0] c_DIVU  = 6'b011011;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    localparam logic [CW-1:0] c_CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] c_CNT_LAST = CW'(1);

    logic [1:0]         r_state, w_state_nxt;
    logic [CW-1:0]      r_cnt, w_cnt_nxt;
    // Shared working register: multu keeps {partial product, multiplier},
    // divu keeps {partial remainder, dividend/quotient}.
    logic [2*WIDTH-1:0] r_acc, w_acc_nxt;
    logic [WIDTH-1:0]   r_opb, w_opb_nxt;
    logic               r_div0, w_div0_nxt;
    logic [WIDTH-1:0]   r_result, w_result_nxt;
    logic [WIDTH-1:0]   r_result_hi, w_result_hi_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic               r_err, w_err_nxt;

    // One shift-add multiply step: add multiplicand into the high half when
    // the current multiplier LSB is set, then shift the whole pair right.
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_step;
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + (r_acc[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
    assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

    // One restoring divide step: shift next dividend bit into the remainder,
    // subtract divisor if it fits. The difference always fits in WIDTH bits
    // when the subtraction is taken, so a modular subtract is sufficient.
    logic [WIDTH:0]     w_div_trial;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_rem;
    logic [2*WIDTH-1:0] w_div_step;
    assign w_div_trial = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_ge    = (w_div_trial >= {1'b0, r_opb});
    assign w_div_rem   = w_div_ge ? (w_div_trial[WIDTH-1:0] - r_opb)
                                  : w_div_trial[WIDTH-1:0];
    assign w_div_step  = {w_div_rem, r_acc[WIDTH-2:0], w_div_ge};

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_acc_nxt       = r_acc;
        w_opb_nxt       = r_opb;
        w_div0_nxt      = r_div0;
        w_result_nxt    = r_result;
        w_result_hi_nxt = r_result_hi;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_err_nxt       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    case (bus.Funct)
                        c_ADDU: begin
                            w_result_nxt = bus.Src1 + bus.Src2;
                            w_done_nxt   = 1'b1;
                        end
                        c_SUBU: begin
                            w_result_nxt = bus.Src1 - bus.Src2;
                            w_done_nxt   = 1'b1;
                        end
                        c_AND: begin
                            w_result_nxt = bus.Src1 & bus.Src2;
                            w_done_nxt   = 1'b1;
                        end
                        c_OR: begin
                            w_result_nxt = bus.Src1 | bus.Src2;
                            w_done_nxt   = 1'b1;
                        end
                        c_SLL: begin
                            w_result_nxt = bus.Src1 << bus.Shamt;
                            w_done_nxt   = 1'b1;
                        end
                        c_SRL: begin
                            w_result_nxt = bus.Src1 >> bus.Shamt;
                            w_done_nxt   = 1'b1;
                        end
                        c_MULTU, c_DIVU: begin
                            w_acc_nxt   = {{WIDTH{1'b0}}, bus.Src1};
                            w_opb_nxt   = bus.Src2;
                            w_div0_nxt  = (bus.Src2 == '0);
                            w_cnt_nxt   = c_CNT_INIT;
                            w_busy_nxt  = 1'b1;
                            w_state_nxt = (bus.Funct == c_MULTU) ? S_MUL : S_DIV;
                        end
                        default: begin
                            w_done_nxt = 1'b1;
                            w_err_nxt  = 1'b1;
                        end
                    endcase
                end
            end
            S_MUL, S_DIV: begin
                w_acc_nxt = (r_state == S_MUL) ? w_mul_step : w_div_step;
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt == c_CNT_LAST) begin
                    w_result_nxt    = w_acc_nxt[WIDTH-1:0];
                    w_result_hi_nxt = w_acc_nxt[2*WIDTH-1:WIDTH];
                    w_err_nxt       = (r_state == S_DIV) && r_div0;
                    w_done_nxt      = 1'b1;
                    w_busy_nxt      = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_opb       <= '0;
            r_div0      <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_acc       <= w_acc_nxt;
            r_opb       <= w_opb_nxt;
            r_div0      <= w_div0_nxt;
            r_result    <= w_result_nxt;
            r_result_hi <= w_result_hi_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.result    = r_result;
    assign bus.result_hi = r_result_hi;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_alu
//  Description : Directed self-checking bench for seq_alu (WIDTH=32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_alu;

    localparam logic [5:0] F_ADDU  = 6'b001011;
    localparam logic [5:0] F_SUBU  = 6'b001101;
    localparam logic [5:0] F_AND   = 6'b010010;
    localparam logic [5:0] F_OR    = 6'b010011;
    localparam logic [5:0] F_SLL   = 6'b100110;
    localparam logic [5:0] F_SRL   = 6'b100100;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    seq_alu_if #(.WIDTH(32)) bus ();

    seq_alu #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one request for exactly one rising edge; returns 1 unit after it
    task automatic drive(input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh);
        @(negedge clk);
        bus.start = 1'b1;
        bus.Funct = f;
        bus.Src1  = a;
        bus.Src2  = b;
        bus.Shamt = sh;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp %h", bus.result, 32'h0); end
        checks++;
        if (bus.result_hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h exp %h", bus.result_hi, 32'h0); end
        checks++;
        if ({bus.busy, bus.done, bus.err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {bus.busy, bus.done, bus.err}); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_arith();
        drive(F_ADDU, 32'hFFFF_FFFF, 32'h0000_0002, 5'd0);
        checks++;
        if (bus.result !== 32'h0000_0001) begin errors++; $display("FAIL addu_wrap got %h exp %h", bus.result, 32'h1); end
        checks++;
        if ({bus.done, bus.err, bus.busy} !== 3'b100) begin errors++; $display("FAIL addu_flags got %b exp 100", {bus.done, bus.err, bus.busy}); end
        checks++;
        if (bus.result_hi !== 32'h0) begin errors++; $display("FAIL addu_hi got %h exp %h", bus.result_hi, 32'h0); end
        @(posedge clk); #1;
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL addu_done_pulse got %b exp 0", bus.done); end
        drive(F_SUBU, 32'd5, 32'd7, 5'd0);
        checks++;
        if (bus.result !== 32'hFFFF_FFFE || bus.done !== 1'b1) begin errors++; $display("FAIL subu got %h done %b exp %h done 1", bus.result, bus.done, 32'hFFFF_FFFE); end
    endtask

    task automatic test_logic_shift();
        drive(F_SLL, 32'h0000_0001, 32'h0, 5'd31);
        checks++;
        if (bus.result !== 32'h8000_0000) begin errors++; $display("FAIL sll got %h exp %h", bus.result, 32'h8000_0000); end
        drive(F_SRL, 32'h8000_0000, 32'h0, 5'd4);
        checks++;
        if (bus.result !== 32'h0800_0000) begin errors++; $display("FAIL srl got %h exp %h", bus.result, 32'h0800_0000); end
        drive(F_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0);
        checks++;
        if (bus.result !== 32'hF000_F000) begin errors++; $display("FAIL and got %h exp %h", bus.result, 32'hF000_F000); end
        drive(F_OR, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0);
        checks++;
        if (bus.result !== 32'hFFF0_FFF0) begin errors++; $display("FAIL or got %h exp %h", bus.result, 32'hFFF0_FFF0); end
    endtask

    task automatic test_multu();
        int bad;
        bad = 0;
        drive(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
        // Cycles E0+1..E0+31: busy, no done; stray starts with new operands
        for (int k = 1; k <= 32; k++) begin
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
            if (k == 5 || k == 6 || k == 20) begin
                bus.start = 1'b1;
                bus.Funct = F_ADDU;
                bus.Src1  = 32'h1234_5678;
                bus.Src2  = 32'h0000_0003;
            end else begin
                bus.start = 1'b0;
            end
            if (k < 32) begin
                @(posedge clk); #1;
            end
        end
        bus.start = 1'b0;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL multu_busy_window bad cycles %0d exp 0", bad); end
        @(posedge clk); #1;
        checks++;
        if ({bus.done, bus.busy, bus.err} !== 3'b100) begin errors++; $display("FAIL multu_done got %b exp 100", {bus.done, bus.busy, bus.err}); end
        checks++;
        if ({bus.result_hi, bus.result} !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL multu_product got %h%h exp %h", bus.result_hi, bus.result, 64'hFFFF_FFFE_0000_0001); end
        @(posedge clk); #1;
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse got %b exp 0", bus.done); end
        drive(F_ADDU, 32'd1, 32'd1, 5'd0);
        checks++;
        if (bus.result_hi !== 32'hFFFF_FFFE || bus.result !== 32'd2) begin errors++; $display("FAIL hi_hold got %h/%h exp %h/%h", bus.result_hi, bus.result, 32'hFFFF_FFFE, 32'd2); end
    endtask

    task automatic test_divu();
        drive(F_DIVU, 32'd100, 32'd7, 5'd0);
        repeat (31) @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL divu_early done %b busy %b exp 0/1", bus.done, bus.busy); end
        @(posedge clk); #1;
        checks++;
        if ({bus.done, bus.err, bus.busy} !== 3'b100 || bus.result !== 32'd14 || bus.result_hi !== 32'd2) begin
            errors++; $display("FAIL divu_100_7 got q=%0d r=%0d flags %b exp q=14 r=2 flags 100", bus.result, bus.result_hi, {bus.done, bus.err, bus.busy});
        end
        // New request accepted during the done cycle
        bus.start = 1'b1; bus.Funct = F_ADDU; bus.Src1 = 32'h10; bus.Src2 = 32'h20;
        @(posedge clk); #1;
        bus.start = 1'b0;
        checks++;
        if (bus.result !== 32'h30 || bus.done !== 1'b1) begin errors++; $display("FAIL start_in_done got %h done %b exp %h done 1", bus.result, bus.done, 32'h30); end

        drive(F_DIVU, 32'h1234, 32'h0, 5'd0);
        repeat (32) @(posedge clk);
        #1;
        checks++;
        if ({bus.done, bus.err} !== 2'b11 || bus.result !== 32'hFFFF_FFFF || bus.result_hi !== 32'h1234) begin
            errors++; $display("FAIL divu_by_zero got q=%h r=%h done/err %b exp q=%h r=%h 11", bus.result, bus.result_hi, {bus.done, bus.err}, 32'hFFFF_FFFF, 32'h1234);
        end
        @(posedge clk); #1;
        checks++;
        if ({bus.done, bus.err} !== 2'b00) begin errors++; $display("FAIL divz_pulse got %b exp 00", {bus.done, bus.err}); end
    endtask

    task automatic test_illegal();
        drive(F_OR, 32'h0000_00A5, 32'h0, 5'd0);
        drive(6'b000000, 32'hDEAD_BEEF, 32'h1, 5'd3);
        checks++;
        if (bus.result !== 32'hA5 || {bus.done, bus.err} !== 2'b11) begin errors++; $display("FAIL illegal got %h done/err %b exp %h 11", bus.result, {bus.done, bus.err}, 32'hA5); end
        checks++;
        if (bus.result_hi !== 32'h1234) begin errors++; $display("FAIL illegal_hi got %h exp %h", bus.result_hi, 32'h1234); end
        @(posedge clk); #1;
        checks++;
        if ({bus.done, bus.err} !== 2'b00) begin errors++; $display("FAIL illegal_pulse got %b exp 00", {bus.done, bus.err}); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.start = 1'b1; bus.Funct = F_ADDU; bus.Src1 = 32'd1; bus.Src2 = 32'd1;
        @(posedge clk); #1;
        checks++;
        if (bus.result !== 32'd2 || bus.done !== 1'b1) begin errors++; $display("FAIL b2b_0 got %h done %b exp 2 done 1", bus.result, bus.done); end
        bus.Funct = F_SUBU; bus.Src1 = 32'd10; bus.Src2 = 32'd3;
        @(posedge clk); #1;
        checks++;
        if (bus.result !== 32'd7 || bus.done !== 1'b1) begin errors++; $display("FAIL b2b_1 got %h done %b exp 7 done 1", bus.result, bus.done); end
        bus.Funct = F_SLL; bus.Src1 = 32'h3; bus.Shamt = 5'd8;
        @(posedge clk); #1;
        bus.start = 1'b0;
        checks++;
        if (bus.result !== 32'h300 || bus.done !== 1'b1) begin errors++; $display("FAIL b2b_2 got %h done %b exp %h done 1", bus.result, bus.done, 32'h300); end
        @(posedge clk); #1;
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL b2b_end got %b exp 0", bus.done); end
    endtask

    task automatic test_reset_mid();
        int seen_done;
        seen_done = 0;
        drive(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.result !== 32'h0 || bus.result_hi !== 32'h0 || {bus.busy, bus.done, bus.err} !== 3'b000) begin
            errors++; $display("FAIL mid_reset got %h/%h flags %b exp 0/0 000", bus.result_hi, bus.result, {bus.busy, bus.done, bus.err});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin errors++; $display("FAIL mid_reset_abort activity cycles %0d exp 0", seen_done); end
        drive(F_ADDU, 32'd3, 32'd4, 5'd0);
        checks++;
        if (bus.result !== 32'd7 || bus.done !== 1'b1) begin errors++; $display("FAIL post_reset_addu got %h done %b exp 7 done 1", bus.result, bus.done); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.Funct = 6'b0;
        bus.Src1  = 32'h0;
        bus.Src2  = 32'h0;
        bus.Shamt = 5'd0;
        test_reset();
        test_arith();
        test_logic_shift();
        test_multu();
        test_divu();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
